// File: rtl/ws2812b_frame_scheduler_pkg.sv
// rtl/ws2812b_frame_scheduler_pkg.sv - shared types and constants for the WS2812B frame scheduler
// Contents:
//   RGB_W        colour word width, {R,G,B} packed
//   IDX_W        LED index width on the write ports
//   state_t      scheduler FSM states
//   tick_period  refresh tick period in system clock cycles
package ws2812b_frame_scheduler_pkg;

  localparam int RGB_W = 24;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_LATCH  = 2'd2
  } state_t;

  function automatic int tick_period(input int sys_freq, input int refresh_hz);
    return sys_freq / refresh_hz;
  endfunction

endpackage

// File: rtl/ws2812b_rr_arb2.sv
// rtl/ws2812b_rr_arb2.sv - two-requester round-robin arbiter
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   en              grants are only issued while en is high
//   req_a, req_b    requests
//   gnt_a, gnt_b    combinational one-hot grant
//   last_b          1 when the most recent grant went to B (reset value 1 so A wins first)
module ws2812b_rr_arb2
  import ws2812b_frame_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic last_b
);

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        gnt_a = last_b;
        gnt_b = !last_b;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (gnt_a) begin
      last_b <= 1'b0;
    end else if (gnt_b) begin
      last_b <= 1'b1;
    end
  end

endmodule

// File: rtl/ws2812b_frame_scheduler.sv
// rtl/ws2812b_frame_scheduler.sv - colour buffer and frame scheduler feeding a WS2812B serializer
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   wr_a_req/idx/rgb, wr_a_ack         requester A buffer write (req held until ack)
//   wr_b_req/idx/rgb, wr_b_ack         requester B buffer write
//   frame_req                          one-cycle pulse forcing a frame
//   pix_valid, pix_rgb, pix_ready      pixel stream to the serializer, {R,G,B}
//   latch_req, latch_done              reset-gap request / completion from the serializer
//   busy, wr_err, frame_count          status: frame in flight, bad-index write, frames sent
module ws2812b_frame_scheduler
  import ws2812b_frame_scheduler_pkg::*;
#(
  parameter int SYS_FREQ   = 12_090_000,
  parameter int NUM_LEDS   = 6,
  parameter int REFRESH_HZ = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_a_req,
  input  logic [IDX_W-1:0] wr_a_idx,
  input  logic [RGB_W-1:0] wr_a_rgb,
  output logic             wr_a_ack,
  input  logic             wr_b_req,
  input  logic [IDX_W-1:0] wr_b_idx,
  input  logic [RGB_W-1:0] wr_b_rgb,
  output logic             wr_b_ack,
  input  logic             frame_req,
  output logic             pix_valid,
  output logic [RGB_W-1:0] pix_rgb,
  input  logic             pix_ready,
  output logic             latch_req,
  input  logic             latch_done,
  output logic             busy,
  output logic             wr_err,
  output logic [15:0]      frame_count
);

  localparam int PERIOD = tick_period(SYS_FREQ, REFRESH_HZ);
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [IDX_W:0]   LEDS_EXT = (IDX_W + 1)'(NUM_LEDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [RGB_W-1:0] buf_mem [NUM_LEDS];
  logic             dirty, pending;
  logic [IDX_W-1:0] pix_idx;
  logic             start, xfer, xfer_last;
  logic             arb_en, req_a, req_b, gnt_a, gnt_b, last_b, gnt_any, gnt_ok;
  logic             ack_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic [RGB_W-1:0] gnt_rgb;

  // Free-running refresh tick; it keeps counting through frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + CNT_W'(1);
  end
  assign tick = (tick_cnt == CNT_W'(PERIOD - 1));

  assign start     = (state == ST_IDLE) && ((tick && dirty) || frame_req || pending);
  assign xfer      = (state == ST_STREAM) && pix_ready;
  assign xfer_last = xfer && (pix_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = (state != ST_IDLE);
    pix_valid = (state == ST_STREAM);
    latch_req = (state == ST_LATCH);
    pix_rgb   = '0;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_STREAM;
      ST_STREAM: begin
        pix_rgb = buf_mem[pix_idx];
        if (xfer_last) state_nx = ST_LATCH;
      end
      ST_LATCH:  if (latch_done) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Starting a frame wins over a write grant; the requester simply keeps
  // req high and is served on a later IDLE cycle. The ack-cycle mask keeps
  // a requester that is just being acked from winning a second time.
  assign arb_en = (state == ST_IDLE) && !start;
  assign req_a  = wr_a_req && !wr_a_ack;
  assign req_b  = wr_b_req && !wr_b_ack;

  ws2812b_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (arb_en),
    .req_a  (req_a),
    .req_b  (req_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .last_b (last_b)
  );

  assign gnt_any = gnt_a || gnt_b;
  assign gnt_idx = gnt_b ? wr_b_idx : wr_a_idx;
  assign gnt_rgb = gnt_b ? wr_b_rgb : wr_a_rgb;
  assign gnt_ok  = ({1'b0, gnt_idx} < LEDS_EXT);

  // The arbiter pointer is updated on the grant edge, so during the ack
  // cycle it names exactly the requester being acknowledged.
  assign wr_a_ack = ack_vld && !last_b;
  assign wr_b_ack = ack_vld && last_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_vld     <= 1'b0;
      wr_err      <= 1'b0;
      dirty       <= 1'b1;
      pending     <= 1'b0;
      pix_idx     <= '0;
      frame_count <= '0;
    end else begin
      ack_vld <= gnt_any;
      wr_err  <= gnt_any && !gnt_ok;
      if (start) begin
        pix_idx <= '0;
        dirty   <= 1'b0;
        pending <= 1'b0;
      end else begin
        if (gnt_any && gnt_ok) dirty <= 1'b1;
        if ((state != ST_IDLE) && ((tick && dirty) || frame_req)) pending <= 1'b1;
      end
      if (xfer) pix_idx <= pix_idx + IDX_W'(1);
      if ((state == ST_LATCH) && latch_done) frame_count <= frame_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) buf_mem[i] <= '0;
    end else if (gnt_any && gnt_ok) begin
      buf_mem[gnt_idx] <= gnt_rgb;
    end
  end

endmodule

// File: tb/tb_ws2812b_frame_scheduler.sv
// tb/tb_ws2812b_frame_scheduler.sv - self-checking bench for ws2812b_frame_scheduler
// Ports: none (top-level bench); drives every DUT port and emulates the serializer.
module tb_ws2812b_frame_scheduler;

  localparam int SYS_FREQ   = 3000;
  localparam int REFRESH_HZ = 10;
  localparam int NUM_LEDS   = 6;
  localparam int PERIOD     = SYS_FREQ / REFRESH_HZ;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_a_req = 1'b0, wr_b_req = 1'b0;
  logic [2:0]  wr_a_idx = '0, wr_b_idx = '0;
  logic [23:0] wr_a_rgb = '0, wr_b_rgb = '0;
  logic        wr_a_ack, wr_b_ack;
  logic        frame_req = 1'b0;
  logic        pix_valid;
  logic [23:0] pix_rgb;
  logic        pix_ready = 1'b0;
  logic        latch_req;
  logic        latch_done = 1'b0;
  logic        busy, wr_err;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  ws2812b_frame_scheduler #(
    .SYS_FREQ   (SYS_FREQ),
    .NUM_LEDS   (NUM_LEDS),
    .REFRESH_HZ (REFRESH_HZ)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_a_req    (wr_a_req),
    .wr_a_idx    (wr_a_idx),
    .wr_a_rgb    (wr_a_rgb),
    .wr_a_ack    (wr_a_ack),
    .wr_b_req    (wr_b_req),
    .wr_b_idx    (wr_b_idx),
    .wr_b_rgb    (wr_b_rgb),
    .wr_b_ack    (wr_b_ack),
    .frame_req   (frame_req),
    .pix_valid   (pix_valid),
    .pix_rgb     (pix_rgb),
    .pix_ready   (pix_ready),
    .latch_req   (latch_req),
    .latch_done  (latch_done),
    .busy        (busy),
    .wr_err      (wr_err),
    .frame_count (frame_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: LED colours as seen by a reader of the buffer, and
  // which requester was acknowledged most recently.
  logic [23:0] model [NUM_LEDS];
  bit          last_was_b;

  // Serializer emulation and observation.
  logic [23:0] cur_frame [8];
  logic [23:0] last_frame [8];
  int          cur_n = 0, last_len = 0, frames_done = 0, lat_wait = -1;
  int          stall_at = -1, stall_left = 0, stab_err = 0;
  bit          prev_hold = 1'b0;
  logic [23:0] prev_rgb = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_n = 0; frames_done = 0; latch_done = 1'b0; pix_ready = 1'b0;
      prev_hold = 1'b0; lat_wait = -1;
    end else begin
      if (prev_hold && (!pix_valid || pix_rgb !== prev_rgb)) stab_err++;
      if (latch_done) latch_done = 1'b0;
      if (pix_valid) begin
        bit rdy;
        if (cur_n == stall_at && stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else begin
          rdy = ($urandom_range(0, 3) != 0);
        end
        pix_ready = rdy;
        if (rdy) begin
          if (cur_n < 8) cur_frame[cur_n] = pix_rgb;
          cur_n++;
        end
        prev_hold = !rdy;
        prev_rgb  = pix_rgb;
      end else begin
        pix_ready = 1'($urandom_range(0, 1));
        prev_hold = 1'b0;
      end
      if (latch_req) begin
        if (lat_wait < 0) lat_wait = $urandom_range(0, 3);
        if (lat_wait == 0) begin
          latch_done = 1'b1;
          last_frame = cur_frame;
          last_len   = cur_n;
          cur_n      = 0;
          frames_done++;
          lat_wait   = -1;
        end else begin
          lat_wait--;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_a_req = 1'b0; wr_b_req = 1'b0; frame_req = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) model[i] = '0;
    last_was_b = 1'b1;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while (!(frames_done >= target && !busy) && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("frame_wait", (frames_done >= target) && !busy, 1'b1);
  endtask

  task automatic check_frame();
    check("frame_len", last_len, NUM_LEDS);
    for (int i = 0; i < NUM_LEDS; i++) check($sformatf("pixel%0d", i), last_frame[i], model[i]);
    check("frame_count", frame_count, 16'(frames_done));
  endtask

  task automatic do_writes(input bit use_a, input bit use_b,
                           input logic [2:0] ia, input logic [2:0] ib,
                           input logic [23:0] ca, input logic [23:0] cb);
    bit got_a, got_b, a_first, exp_a_first;
    int t;
    got_a = !use_a; got_b = !use_b; a_first = 1'b0;
    exp_a_first = last_was_b;
    @(negedge clk);
    wr_a_idx = ia; wr_a_rgb = ca; wr_b_idx = ib; wr_b_rgb = cb;
    wr_a_req = use_a; wr_b_req = use_b;
    t = 0;
    while (!(got_a && got_b) && t < 300) begin
      @(negedge clk);
      t++;
      if (wr_a_ack && wr_b_ack) check("one_ack_per_cycle", 2'b11, 2'b01);
      if (wr_a_ack) begin
        check("dup_ack_a", got_a, 1'b0);
        check("wr_err_a", wr_err, (32'(ia) >= NUM_LEDS));
        if (!got_b) a_first = 1'b1;
        got_a = 1'b1; wr_a_req = 1'b0; last_was_b = 1'b0;
        if (32'(ia) < NUM_LEDS) model[ia] = ca;
      end
      if (wr_b_ack) begin
        check("dup_ack_b", got_b, 1'b0);
        check("wr_err_b", wr_err, (32'(ib) >= NUM_LEDS));
        got_b = 1'b1; wr_b_req = 1'b0; last_was_b = 1'b1;
        if (32'(ib) < NUM_LEDS) model[ib] = cb;
      end
    end
    check("write_done", got_a && got_b, 1'b1);
    if (use_a && use_b) check("rr_order", a_first, exp_a_first);
    wr_a_req = 1'b0; wr_b_req = 1'b0;
  endtask

  initial begin
    int t, d, fc0, mode;
    bit early;
    logic [2:0] ia, ib;

    // Reset state, then the first tick blanks the chain.
    enter_reset();
    repeat (3) @(negedge clk);
    check("reset_ctrl", {pix_valid, latch_req, busy, wr_err, wr_a_ack, wr_b_ack}, '0);
    check("reset_pix_rgb", pix_rgb, 24'h0);
    check("reset_frame_count", frame_count, 16'h0);
    rst_n = 1'b1;
    t = 0;
    while (!busy && t < PERIOD + 50) begin
      @(negedge clk);
      t++;
    end
    check("tick_latency", t, PERIOD);
    wait_frames(1);
    check_frame();
    check("first_frame_count", frame_count, 16'd1);

    // Simultaneous A/B writes to the same LED right after reset.
    enter_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_writes(1'b1, 1'b1, 3'd2, 3'd2, 24'hFF0000, 24'h00FF00);
    check("model_led2", model[2], 24'h00FF00);
    wait_frames(1);
    check_frame();

    // Randomized single and simultaneous writes, including bad indices.
    for (int it = 0; it < 12; it++) begin
      mode = $urandom_range(0, 2);
      ia = 3'($urandom_range(0, 7));
      ib = 3'($urandom_range(0, 7));
      do_writes(mode != 1, mode != 0, ia, ib, 24'($urandom), 24'($urandom));
    end
    wait_idle("idle_before_rand_frame");
    fc0 = frames_done;
    pulse_frame();
    wait_frames(fc0 + 1);
    check_frame();

    // Distinct contents, then a 5-cycle stall on pixel 3.
    for (int i = 0; i < NUM_LEDS; i++)
      do_writes(1'b1, 1'b0, 3'(i), 3'd0, 24'(32'h111111 * (i + 1)), 24'h0);
    wait_idle("idle_before_stall");
    stab_err = 0;
    stall_at = 3;
    stall_left = 5;
    fc0 = frames_done;
    pulse_frame();
    wait_frames(fc0 + 1);
    check_frame();
    check("stall_applied", stall_left, 0);
    check("pix_stable", stab_err, 0);
    stall_at = -1;

    // Out-of-range write: acked with wr_err, no buffer change, no new frame.
    wait_idle("idle_before_bad_write");
    fc0 = frames_done;
    do_writes(1'b1, 1'b0, 3'd7, 3'd0, 24'hABCDEF, 24'h0);
    repeat (PERIOD + 20) @(negedge clk);
    check("bad_write_no_frame", frames_done, fc0);
    check("bad_write_frame_count", frame_count, 16'(fc0));
    pulse_frame();
    wait_frames(fc0 + 1);
    check_frame();

    // frame_req during LATCH queues exactly one more frame.
    wait_idle("idle_before_pending");
    fc0 = frames_done;
    pulse_frame();
    t = 0;
    while (!latch_req && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("reach_latch", latch_req, 1'b1);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("latch_exit", busy, 1'b0);
    @(negedge clk);
    check("pending_restart", {busy, pix_valid}, 2'b11);
    wait_frames(fc0 + 2);
    check_frame();
    repeat (30) @(negedge clk);
    check("no_extra_frame", frames_done, fc0 + 2);

    // Write held across a frame: no ack while busy, ack soon after IDLE.
    pulse_frame();
    t = 0;
    while (!busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("frame_started", busy, 1'b1);
    wr_a_idx = 3'd4; wr_a_rgb = 24'($urandom); wr_a_req = 1'b1;
    early = 1'b0;
    t = 0;
    while (busy && t < 300) begin
      if (wr_a_ack) early = 1'b1;
      @(negedge clk);
      t++;
    end
    check("no_ack_while_busy", early, 1'b0);
    d = 0;
    while (!wr_a_ack && d < 10) begin
      @(negedge clk);
      d++;
    end
    check("ack_after_idle", (d >= 1) && (d <= 2), 1'b1);
    wr_a_req = 1'b0;
    model[4] = wr_a_rgb;
    last_was_b = 1'b0;

    // Reset in the middle of a stream aborts at once.
    pulse_frame();
    t = 0;
    while (!pix_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("stream_before_reset", pix_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_pix_valid", pix_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_frame_count", frame_count, 16'h0);
    for (int i = 0; i < NUM_LEDS; i++) model[i] = '0;
    last_was_b = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_frames(1);
    check_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
